dm_stage_m: RTL and testbench

Memory-stage data memory for the five-stage MIPS pipeline. Consumes the instruction, ALU-computed address and rt store value latched by the E→M pipeline register, and performs word/halfword/byte stores into an internal RAM. Returns width- and sign-extended load data to the M→W register. Sticky misalignment/out-of-range capture for the test bench and later exception support.

---
 rtl/dm_stage_m.sv | 183 ++++++++++++++++++
 tb/tb_dm_stage_m.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stage_m.sv
// Memory-stage data RAM: word/half/byte stores, extended loads,
// and sticky capture of the first misaligned or out-of-range access.
module dm_stage_m #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] pc_add_4,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fault_pc,
  output logic [31:0] store_count
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  logic [31:0]   mem_q [DEPTH];

  logic [5:0]    op;
  logic          is_ld;
  logic          is_st;
  logic          sx;
  size_e         sz;
  logic          misal;
  logic          oor;
  logic          flt;
  logic          st_en;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic [31:0]   rword;
  logic [15:0]   rhalf;
  logic [7:0]    rbyte;
  logic [31:0]   rdata;

  logic          fault_q;
  logic          fault_d;
  logic [31:0]   fa_q;
  logic [31:0]   fa_d;
  logic [31:0]   fp_q;
  logic [31:0]   fp_d;
  logic [31:0]   sc_q;
  logic [31:0]   sc_d;

  logic          unused_ok;
  assign unused_ok = ^Instruction[25:0];

  assign op   = Instruction[31:26];
  assign idx  = MemAddr[AW+1:2];
  assign lane = MemAddr[1:0];

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sx    = 1'b0;
    sz    = SZ_W;
    case (op)
      OP_LW:  begin is_ld = 1'b1; sz = SZ_W; end
      OP_LH:  begin is_ld = 1'b1; sz = SZ_H; sx = 1'b1; end
      OP_LHU: begin is_ld = 1'b1; sz = SZ_H; end
      OP_LB:  begin is_ld = 1'b1; sz = SZ_B; sx = 1'b1; end
      OP_LBU: begin is_ld = 1'b1; sz = SZ_B; end
      OP_SW:  begin is_st = 1'b1; sz = SZ_W; end
      OP_SH:  begin is_st = 1'b1; sz = SZ_H; end
      OP_SB:  begin is_st = 1'b1; sz = SZ_B; end
      default: ;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    case (sz)
      SZ_W:    misal = |lane;
      SZ_H:    misal = lane[0];
      default: misal = 1'b0;
    endcase
    oor   = (MemAddr >> (AW + 2)) != 32'd0;
    flt   = (is_ld | is_st) & (misal | oor);
    st_en = is_st & ~flt;
  end

  // Lane enables and lane-replicated write data
  always_comb begin
    be   = 4'b1111;
    wdat = WriteData;
    case (sz)
      SZ_H: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{WriteData[15:0]}};
      end
      SZ_B: begin
        be   = 4'b0001 << lane;
        wdat = {4{WriteData[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rword = mem_q[idx];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    rbyte = rword[8*lane +: 8];
    rdata = 32'd0;
    if (is_ld && !flt) begin
      case (sz)
        SZ_W:    rdata = rword;
        SZ_H:    rdata = {{16{sx & rhalf[15]}}, rhalf};
        default: rdata = {{24{sx & rbyte[7]}}, rbyte};
      endcase
    end
  end

  assign ReadData = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
  end

  // Only the first faulting access is recorded
  always_comb begin
    fault_d = fault_q;
    fa_d    = fa_q;
    fp_d    = fp_q;
    sc_d    = sc_q;
    if (st_en) begin
      sc_d = sc_q + 32'd1;
    end
    if (flt && !fault_q) begin
      fault_d = 1'b1;
      fa_d    = MemAddr;
      fp_d    = pc_add_4 - 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
      fa_q    <= '0;
      fp_q    <= '0;
      sc_q    <= '0;
    end else begin
      fault_q <= fault_d;
      fa_q    <= fa_d;
      fp_q    <= fp_d;
      sc_q    <= sc_d;
    end
  end

  assign fault       = fault_q;
  assign fault_addr  = fa_q;
  assign fault_pc    = fp_q;
  assign store_count = sc_q;

endmodule

// File: tb/tb_dm_stage_m.sv
// Bench for dm_stage_m: directed plan plus random traffic
// against a byte-array reference model and scoreboard.
module tb_dm_stage_m;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic [31:0] pc_add_4;
  logic [31:0] MemAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fault_pc;
  logic [31:0] store_count;

  dm_stage_m #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .pc_add_4    (pc_add_4),
    .MemAddr     (MemAddr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .fault_pc    (fault_pc),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    logic [31:0] fa;
    logic [31:0] fp;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic        tx_v = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [7:0]  mm [4*DEPTH];
  logic        m_flt;
  logic [31:0] m_fa;
  logic [31:0] m_fp;
  logic [31:0] m_sc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h00;
    m_flt = 1'b0;
    m_fa  = '0;
    m_fp  = '0;
    m_sc  = '0;
  endtask

  // Drive one M-stage cycle, predict, push expectation, update model
  task automatic issue(input bit rst, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc4);
    bit          ld;
    bit          st;
    bit          sx;
    bit          bad;
    int          sz;
    logic [31:0] r;
    exp_t        x;
    ld = 0; st = 0; sx = 0; sz = 4; bad = 0; r = '0;
    case (op)
      6'h23: begin ld = 1; sz = 4; end
      6'h21: begin ld = 1; sz = 2; sx = 1; end
      6'h25: begin ld = 1; sz = 2; end
      6'h20: begin ld = 1; sz = 1; sx = 1; end
      6'h24: begin ld = 1; sz = 1; end
      6'h2B: begin st = 1; sz = 4; end
      6'h29: begin st = 1; sz = 2; end
      6'h28: begin st = 1; sz = 1; end
      default: ;
    endcase
    if (ld || st)
      bad = (a >= 32'(4*DEPTH)) || ((a & 32'(sz - 1)) != 0);
    if (ld && !bad) begin
      for (int k = 0; k < sz; k++) r[8*k +: 8] = mm[a + 32'(k)];
      if (sx && sz == 1) r = {{24{r[7]}}, r[7:0]};
      if (sx && sz == 2) r = {{16{r[15]}}, r[15:0]};
    end
    x.rd = r; x.flt = m_flt; x.fa = m_fa; x.fp = m_fp; x.sc = m_sc;
    @(posedge clk);
    #1;
    reset       = rst;
    Instruction = (op == 6'h00) ? 32'd0 : {op, 5'd3, 5'd4, a[15:0]};
    MemAddr     = a;
    WriteData   = wd;
    pc_add_4    = pc4;
    q.push_back(x);
    tx_v = 1'b1;
    if (rst) begin
      model_reset();
    end else begin
      if (st && !bad) begin
        for (int k = 0; k < sz; k++) mm[a + 32'(k)] = wd[8*k +: 8];
        m_sc = m_sc + 1;
      end
      if ((ld || st) && bad && !m_flt) begin
        m_flt = 1'b1;
        m_fa  = a;
        m_fp  = pc4 - 4;
      end
    end
  endtask

  task automatic bub();
    issue(0, 6'h00, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rst1();
    issue(1, 6'h00, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic at_neg(input string nm, input logic [31:0] act_sel_rd,
                        input logic [31:0] exp);
    chk(nm, act_sel_rd, exp);
  endtask

  always @(negedge clk) begin
    if (tx_v) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_empty: got none want entry");
      end else begin
        e = q.pop_front();
        chk("sb_rdata", ReadData, e.rd);
        chk("sb_fault", 32'(fault), 32'(e.flt));
        chk("sb_faddr", fault_addr, e.fa);
        chk("sb_fpc", fault_pc, e.fp);
        chk("sb_scount", store_count, e.sc);
      end
    end
  end

  logic [5:0] ops [11];
  initial begin
    ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28,
            6'h00, 6'h0F, 6'h08};
    reset = 1'b1; Instruction = '0; MemAddr = '0;
    WriteData = '0; pc_add_4 = '0;
    repeat (2) @(posedge clk);
    model_reset();
    rst1();

    issue(0, 6'h2B, 32'h10, 32'h12345678, 32'h104);
    issue(0, 6'h23, 32'h10, 32'h0, 32'h108);
    @(negedge clk); chk("lw_rt", ReadData, 32'h12345678);
    bub();
    @(negedge clk); chk("sc_one", store_count, 32'd1);

    issue(0, 6'h2B, 32'h20, 32'h0, 32'h200);
    issue(0, 6'h28, 32'h21, 32'h1FF, 32'h204);
    issue(0, 6'h29, 32'h22, 32'hABCD8001, 32'h208);
    issue(0, 6'h23, 32'h20, 32'h0, 32'h20C);
    @(negedge clk); chk("lw_lanes", ReadData, 32'h8001FF00);
    issue(0, 6'h20, 32'h21, 32'h0, 32'h210);
    @(negedge clk); chk("lb", ReadData, 32'hFFFFFFFF);
    issue(0, 6'h24, 32'h21, 32'h0, 32'h214);
    @(negedge clk); chk("lbu", ReadData, 32'h000000FF);
    issue(0, 6'h21, 32'h22, 32'h0, 32'h218);
    @(negedge clk); chk("lh", ReadData, 32'hFFFF8001);
    issue(0, 6'h25, 32'h22, 32'h0, 32'h21C);
    @(negedge clk); chk("lhu", ReadData, 32'h00008001);

    issue(0, 6'h2B, 32'h31, 32'hDEADBEEF, 32'h3004);
    issue(0, 6'h23, 32'h30, 32'h0, 32'h3008);
    @(negedge clk);
    chk("mis_nowr", ReadData, 32'h0);
    chk("mis_flt", 32'(fault), 32'd1);
    chk("mis_fa", fault_addr, 32'h31);
    chk("mis_fp", fault_pc, 32'h3000);
    chk("mis_sc", store_count, 32'd4);
    issue(0, 6'h21, 32'h43, 32'h0, 32'h3010);
    @(negedge clk); chk("sticky_rd", ReadData, 32'h0);
    bub();
    @(negedge clk);
    chk("sticky_fa", fault_addr, 32'h31);
    chk("sticky_fp", fault_pc, 32'h3000);

    rst1();
    issue(0, 6'h2B, 32'h1000, 32'hCAFEF00D, 32'h4004);
    issue(0, 6'h23, 32'h0, 32'h0, 32'h4008);
    @(negedge clk);
    chk("oor_alias", ReadData, 32'h0);
    chk("oor_flt", 32'(fault), 32'd1);
    chk("oor_fa", fault_addr, 32'h1000);
    issue(0, 6'h2B, 32'hFFC, 32'h77, 32'h400C);
    issue(0, 6'h23, 32'hFFC, 32'h0, 32'h4010);
    @(negedge clk); chk("top_word", ReadData, 32'h77);

    issue(0, 6'h2B, 32'h8, 32'h55, 32'h5004);
    issue(1, 6'h2B, 32'hC, 32'h99, 32'h5008);
    issue(0, 6'h23, 32'h8, 32'h0, 32'h500C);
    @(negedge clk);
    chk("rst_ld", ReadData, 32'h0);
    chk("rst_flt", 32'(fault), 32'd0);
    chk("rst_sc", store_count, 32'd0);
    issue(0, 6'h23, 32'hC, 32'h0, 32'h5010);
    @(negedge clk); chk("rst_st_drop", ReadData, 32'h0);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a;
      logic [5:0]  op;
      int          p;
      op = ops[$urandom_range(0, 10)];
      p  = $urandom_range(0, 99);
      if (p < 70)      a = 32'($urandom_range(0, 63));
      else if (p < 85) a = 32'($urandom_range(32'hFC0, 32'hFFF));
      else if (p < 95) a = 32'($urandom_range(32'h1000, 32'h1010));
      else             a = $urandom;
      if (p < 60) begin
        if (op == 6'h23 || op == 6'h2B) a = a & ~32'd3;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) a = a & ~32'd1;
      end
      issue($urandom_range(0, 99) == 0, op, a, $urandom,
            {$urandom_range(1, 32'h3FFFFFF), 2'b00});
    end

    @(negedge clk);
    #1 tx_v = 1'b0;
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
